// File: rtl/fp_acc_pkg.sv
// Shared FSM state, IEEE-754 single field constants and the operand sanitiser.
// Exponent-255 handling of the sanitiser depends on FP_ACC_SPECIAL_EN.
package fp_acc_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, EMIT} state_t;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

    // Denormals become signed zero; without special support, Inf/NaN become signed max finite.
    function automatic logic [31:0] sanitize(input logic [31:0] w);
        if (w[30:23] == 8'd0)
            return {w[31], 31'd0};
`ifndef FP_ACC_SPECIAL_EN
        if (w[30:23] == 8'hFF)
            return {w[31], MAX_FIN[30:0]};
`endif
        return w;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Barrel right shift of a 24-bit mantissa (hidden bit included) by an exponent difference.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module fp_align_shift
    import fp_acc_pkg::*;
(
    input  logic [MAN_W:0]   man,
    input  logic [EXP_W-1:0] amt,
    output logic [MAN_W:0]   res
);

    // Any shift of the full mantissa width or more leaves nothing.
    assign res = (amt >= 8'(MAN_W + 1)) ? '0 : (man >> amt);

endmodule

// File: rtl/fp_accumulator.sv
// Streaming single-precision accumulator; emits the sum and element count when in_last arrives.
// Latency: accept -> ALIGN -> ADD -> NORM (1+ cycles, one shift per cycle); truncating rounding.
// Backpressure: in_ready only in IDLE; EMIT holds out_data/out_count until out_ready. FP_ACC_SPECIAL_EN enables NaN/Inf.
module fp_accumulator
    import fp_acc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    state_t             state;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   count;
    logic [31:0]        opd;
    logic               last_q;

    logic               b_sign;
    logic [EXP_W-1:0]   b_exp;
    logic [MAN_W:0]     b_man;
    logic [MAN_W:0]     s_man;
    logic               sub_q;
    logic               zsign;
    logic [EXP_W:0]     n_exp;
    logic [MAN_W:0]     n_man;

    // Alignment: the larger magnitude (operand on ties) becomes the base.
    logic               swap;
    logic [31:0]        big_w;
    logic [EXP_W-1:0]   sml_exp;
    logic [MAN_W-1:0]   sml_frac;
    logic [MAN_W:0]     big_m;
    logic [MAN_W:0]     sml_m;
    logic [MAN_W:0]     sml_sh;
    logic [EXP_W-1:0]   diff;

    assign swap     = opd[30:0] >= acc[30:0];
    assign big_w    = swap ? opd : acc;
    assign sml_exp  = swap ? acc[30:23] : opd[30:23];
    assign sml_frac = swap ? acc[22:0] : opd[22:0];
    assign big_m    = {big_w[30:23] != 8'd0, big_w[22:0]};
    assign sml_m    = {sml_exp != 8'd0, sml_frac};
    assign diff     = big_w[30:23] - sml_exp;

    fp_align_shift u_align (
        .man (sml_m),
        .amt (diff),
        .res (sml_sh)
    );

`ifdef FP_ACC_SPECIAL_EN
    logic        spc_vld;
    logic [31:0] spc_word;
    logic        a_nan, a_inf, i_nan, i_inf;
    logic        spc_vld_d;
    logic [31:0] spc_word_d;

    assign a_nan = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);
    assign a_inf = (acc[30:23] == 8'hFF) && (acc[22:0] == 23'd0);
    assign i_nan = (opd[30:23] == 8'hFF) && (opd[22:0] != 23'd0);
    assign i_inf = (opd[30:23] == 8'hFF) && (opd[22:0] == 23'd0);

    always_comb begin
        spc_vld_d  = 1'b1;
        spc_word_d = QNAN;
        if (a_nan || i_nan || (a_inf && i_inf && (acc[31] != opd[31])))
            spc_word_d = QNAN;
        else if (a_inf)
            spc_word_d = acc;
        else if (i_inf)
            spc_word_d = opd;
        else
            spc_vld_d = 1'b0;
    end
    localparam logic [30:0] OVF_MAG = POS_INF[30:0];
`else
    localparam logic [30:0] OVF_MAG = MAX_FIN[30:0];
`endif

    logic [MAN_W+1:0] sum;
    assign sum = sub_q ? ({1'b0, b_man} - {1'b0, s_man})
                       : ({1'b0, b_man} + {1'b0, s_man});

    logic        norm_done;
    logic [31:0] norm_res;

    always_comb begin
        norm_done = 1'b1;
        norm_res  = {b_sign, n_exp[EXP_W-1:0], n_man[MAN_W-1:0]};
        if (n_exp >= (EXP_W+1)'(EXP_MAX))
            norm_res = {b_sign, OVF_MAG};
        else if (n_man == '0)
            norm_res = {zsign, 31'd0};
        else if (n_man[MAN_W])
            norm_res = {b_sign, n_exp[EXP_W-1:0], n_man[MAN_W-1:0]};
        else if (n_exp <= (EXP_W+1)'(1))
            norm_res = 32'd0;
        else
            norm_done = 1'b0;
`ifdef FP_ACC_SPECIAL_EN
        if (spc_vld) begin
            norm_done = 1'b1;
            norm_res  = spc_word;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= 32'd0;
            count     <= '0;
            opd       <= 32'd0;
            last_q    <= 1'b0;
            b_sign    <= 1'b0;
            b_exp     <= '0;
            b_man     <= '0;
            s_man     <= '0;
            sub_q     <= 1'b0;
            zsign     <= 1'b0;
            n_exp     <= '0;
            n_man     <= '0;
`ifdef FP_ACC_SPECIAL_EN
            spc_vld   <= 1'b0;
            spc_word  <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        opd      <= sanitize(in_data);
                        last_q   <= in_last;
                        count    <= count + CNT_W'(1);
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    b_sign <= big_w[31];
                    b_exp  <= big_w[30:23];
                    b_man  <= big_m;
                    s_man  <= sml_sh;
                    sub_q  <= opd[31] ^ acc[31];
                    // Signed zero survives only when zero is added to zero.
                    zsign  <= (acc[30:0] == 31'd0 && opd[30:0] == 31'd0) ? opd[31] : 1'b0;
`ifdef FP_ACC_SPECIAL_EN
                    spc_vld  <= spc_vld_d;
                    spc_word <= spc_word_d;
`endif
                    state  <= ADD;
                end
                ADD: begin
                    if (sum[MAN_W+1]) begin
                        n_man <= sum[MAN_W+1:1];
                        n_exp <= {1'b0, b_exp} + (EXP_W+1)'(1);
                    end else begin
                        n_man <= sum[MAN_W:0];
                        n_exp <= {1'b0, b_exp};
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (norm_done) begin
                        acc <= norm_res;
                        if (last_q) begin
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        n_man <= n_man << 1;
                        n_exp <= n_exp - (EXP_W+1)'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= 32'd0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data  = acc;
    assign out_count = count;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed-vector bench for fp_accumulator; expected sums are hand-computed IEEE-754 words.
// Special-value expectations follow FP_ACC_SPECIAL_EN.
module tb_fp_accumulator;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    int tests = 0;
    int fails = 0;

    fp_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns #1 after the accepting clock edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL wait_out_timeout: out_valid=%0b required 1 within 100 cycles", out_valid);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        tests++; if (out_count !== 16'd0) begin fails++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic_sum();
        send(32'h40A00000, 1'b0);
        send(32'h41000000, 1'b1);
        wait_out();
        tests++; if (out_data !== 32'h41500000) begin fails++; $display("FAIL sum_5_8: got %h want 41500000", out_data); end
        tests++; if (out_count !== 16'd2) begin fails++; $display("FAIL count_5_8: got %0d want 2", out_count); end
        handshake();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_hs_valid: got %0b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_hs_ready: got %0b want 1", in_ready); end
        tests++; if (out_count !== 16'd0) begin fails++; $display("FAIL post_hs_count: got %0d want 0", out_count); end
    endtask

    task automatic test_cancel();
        send(32'h40A00000, 1'b0);
        send(32'hC0400000, 1'b1);
        wait_out();
        tests++; if (out_data !== 32'h40000000) begin fails++; $display("FAIL sum_5_m3: got %h want 40000000", out_data); end
        handshake();
        send(32'h41100000, 1'b0);
        send(32'hC1100000, 1'b1);
        wait_out();
        tests++; if (out_data !== 32'h00000000) begin fails++; $display("FAIL sum_9_m9: got %h want 00000000", out_data); end
        tests++; if (out_count !== 16'd2) begin fails++; $display("FAIL count_9_m9: got %0d want 2", out_count); end
        handshake();
    endtask

    task automatic test_three();
        logic [31:0] vals [3];
        vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
        for (int k = 0; k < 3; k++) begin
            send(vals[k], k == 2);
            // ALIGN, ADD and a single NORM cycle: in_ready stays low for all three.
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_ready elem%0d cyc%0d: got %0b want 0", k, c, in_ready); end
                if (c < 2) begin @(posedge clk); #1; end
            end
            if (k < 2) begin
                @(posedge clk); #1;
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_ready elem%0d: got %0b want 1", k, in_ready); end
            end
        end
        wait_out();
        tests++; if (out_data !== 32'h40C00000) begin fails++; $display("FAIL sum_1_2_3: got %h want 40C00000", out_data); end
        tests++; if (out_count !== 16'd3) begin fails++; $display("FAIL count_1_2_3: got %0d want 3", out_count); end
        handshake();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ovf, exp_inf;
`ifdef FP_ACC_SPECIAL_EN
        exp_ovf = 32'h7F800000;
        exp_inf = 32'h7F800000;
`else
        exp_ovf = 32'h7F7FFFFF;
        exp_inf = 32'h7F7FFFFF;
`endif
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);
        wait_out();
        tests++; if (out_data !== exp_ovf) begin fails++; $display("FAIL overflow: got %h want %h", out_data, exp_ovf); end
        handshake();
        send(32'h7F800000, 1'b0);
        send(32'h5CA00000, 1'b1);
        wait_out();
        tests++; if (out_data !== exp_inf) begin fails++; $display("FAIL inf_plus_fin: got %h want %h", out_data, exp_inf); end
        handshake();
    endtask

    task automatic test_backpressure();
        send(32'h40A00000, 1'b0);
        send(32'h41000000, 1'b1);
        wait_out();
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h41500000 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold cyc%0d: valid=%0b data=%h ready=%0b want 1/41500000/0", c, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_norm();
        int seen = 0;
        send(32'h40A00000, 1'b0);
        send(32'hC0400000, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        // First of two NORM cycles for 5.0 - 3.0.
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 16'd0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midnorm_reset: valid=%0b data=%h count=%0d ready=%0b want 0/00000000/0/0", out_valid, out_data, out_count, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midnorm_no_valid: out_valid cycles=%0d want 0", seen); end
        send(32'h40A00000, 1'b0);
        send(32'h41000000, 1'b1);
        wait_out();
        tests++; if (out_data !== 32'h41500000) begin fails++; $display("FAIL after_reset_sum: got %h want 41500000", out_data); end
        tests++; if (out_count !== 16'd2) begin fails++; $display("FAIL after_reset_count: got %0d want 2", out_count); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_cancel();
        test_three();
        test_overflow();
        test_backpressure();
        test_reset_mid_norm();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the element counter output.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand present.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single operand.
REQ-007 SHALL have port in_last  input  1  operand is final element of the current sum.
REQ-008 SHALL have port out_valid  output  1  sum available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the sum.
REQ-010 SHALL have port out_data  output  32  accumulated single-precision sum.
REQ-011 SHALL have port out_count  output  CNT_W  number of elements in the sum, wrapping modulo 2^CNT_W.

Function
REQ-012 SHALL use FSM states IDLE, ALIGN, ADD, NORM, EMIT.
REQ-013 SHALL assert in_ready only in IDLE; an operand is accepted when in_valid and in_ready are both high on a clock edge (IDLE->ALIGN), capturing in_data and in_last.
REQ-014 ALIGN (1 cycle): SHALL compare exponents, swap so that the larger magnitude is first, and barrel-right-shift the smaller 24-bit mantissa (hidden bit included) by the exponent difference; a difference >= 25 SHALL make the smaller operand zero.
REQ-015 ADD (1 cycle): SHALL add mantissas for equal signs and subtract for unequal signs; on carry-out it SHALL shift right 1 and increment the exponent in the same cycle.
REQ-016 NORM: SHALL shift the mantissa left one bit per cycle, decrementing the exponent, until bit 23 is set; NORM SHALL take at least 1 cycle.
REQ-017 NORM SHALL exit to EMIT if the captured in_last is set; otherwise it SHALL exit to IDLE.
REQ-018 Rounding SHALL be truncation (toward zero); bits shifted out during ALIGN/ADD SHALL be discarded.
REQ-019 Denormal inputs SHALL be flushed to signed zero; an exponent underflow in NORM SHALL produce +0.
REQ-020 Exact cancellation SHALL give +0 (0x00000000); if the accumulator is zero, the result SHALL equal the (flushed) input.
REQ-021 EMIT: out_valid SHALL be high and out_data/out_count SHALL be held stable until out_ready; on handshake the accumulator SHALL clear to +0, the count to 0, and the FSM SHALL return to IDLE.
REQ-022 out_valid and in_ready SHALL never both be high.
REQ-023 out_count SHALL increment once per accepted operand.

Reset
REQ-024 Asserting rst_n low at any time, including mid-operation, SHALL force IDLE, accumulator +0, out_count 0, out_valid 0, out_data 0, in_ready 0 while in reset and 1 on the first cycle after release; an in-flight operand SHALL be discarded.

Configuration
REQ-025 With FP_ACC_SPECIAL_EN defined: NaN inputs SHALL make the sum the sticky value 0x7FC00000; Inf inputs SHALL make it signed Inf (+Inf plus -Inf gives 0x7FC00000); exponent overflow SHALL give signed Inf.
REQ-026 Without FP_ACC_SPECIAL_EN: inputs with exponent 255 SHALL be treated as signed max finite (0x7F7FFFFF magnitude); overflow SHALL saturate to signed 0x7F7FFFFF.

Structure
REQ-027 Package fp_acc_pkg SHALL hold the FSM state enum, field-width constants (EXP_W=8, MAN_W=23, BIAS=127), and the constants QNAN, POS_INF, MAX_FIN.
REQ-028 Leading-zero normalization SHALL remain inline; the barrel aligner SHALL be the single sub-module fp_align_shift (24-bit in, 8-bit shift amount, 24-bit out).

Verification
REQ-029 5.0 (0x40A00000), then 8.0 (0x41000000) with in_last -> out_data 0x41500000 (13.0), out_count 2.
REQ-030 5.0, then -3.0 (0xC0400000) with last -> 0x40000000; 9.0 (0x41100000), then -9.0 (0xC1100000) with last -> 0x00000000.
REQ-031 1.0, 2.0, 3.0 (last) -> 0x40C00000, out_count 3; in_ready low from acceptance through NORM of each element.
REQ-032 0x7F7FFFFF + 0x7F7FFFFF (last) -> 0x7F800000 with FP_ACC_SPECIAL_EN defined, 0x7F7FFFFF without; 0x7F800000 + 0x5CA00000 with macro defined -> 0x7F800000.
REQ-033 out_ready held low 5 cycles in EMIT -> out_valid high and out_data stable throughout, in_ready 0; release -> one-cycle handshake, then IDLE.
REQ-034 rst_n pulsed low during NORM -> outputs reset at once, with no out_valid afterwards; the next sum of 5.0 + 8.0 -> 0x41500000.
